// File: rtl/pipeline_de_hz.sv
// Decode/execute pipeline register with valid bit, stall, flush, load-use
// hazard detection with automatic bubble insertion, and a saturating bubble counter.
module pipeline_de_hz #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 3,
  parameter int REGW  = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EnE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic [CTRLW-1:0] CtrlD,
  input  logic             IsLoadD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [REGW-1:0]  Rs1D,
  input  logic [REGW-1:0]  Rs2D,
  input  logic [REGW-1:0]  RdD,
  output logic             ValidE,
  output logic [CTRLW-1:0] CtrlE,
  output logic             IsLoadE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [REGW-1:0]  Rs1E,
  output logic [REGW-1:0]  Rs2E,
  output logic [REGW-1:0]  RdE,
  output logic             LoadUseD,
  output logic [CNTW-1:0]  BubbleCnt
);

  logic             r_valid;
  logic [CTRLW-1:0] r_ctrl;
  logic             r_is_load;
  logic [XLEN-1:0]  r_rd1;
  logic [XLEN-1:0]  r_rd2;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pc_plus4;
  logic [XLEN-1:0]  r_imm;
  logic [REGW-1:0]  r_rs1;
  logic [REGW-1:0]  r_rs2;
  logic [REGW-1:0]  r_rd;
  logic [CNTW-1:0]  r_bubble_cnt;

  logic w_load_use;
  logic w_bubble;
  logic w_cnt_sat;

  // x0 is never a real producer, so RdE == 0 cannot create a dependency
  assign w_load_use = r_valid & r_is_load & (r_rd != '0) & ValidD &
                      ((Rs1D == r_rd) | (Rs2D == r_rd));
  // A stalled stage holds the load in E; it must not be replaced by a bubble
  assign w_bubble   = FlushE | (EnE & w_load_use);
  assign w_cnt_sat  = &r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_is_load  <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (EnE) begin
      r_valid    <= ValidD;
      r_ctrl     <= CtrlD;
      r_is_load  <= IsLoadD;
      r_rd1      <= RD1D;
      r_rd2      <= RD2D;
      r_pc       <= PCD;
      r_pc_plus4 <= PCPlus4D;
      r_imm      <= ImmExtD;
      r_rs1      <= Rs1D;
      r_rs2      <= Rs2D;
      r_rd       <= RdD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && !w_cnt_sat) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ValidE    = r_valid;
  assign CtrlE     = r_ctrl;
  assign IsLoadE   = r_is_load;
  assign RD1E      = r_rd1;
  assign RD2E      = r_rd2;
  assign PCE       = r_pc;
  assign PCPlus4E  = r_pc_plus4;
  assign ImmExtE   = r_imm;
  assign Rs1E      = r_rs1;
  assign Rs2E      = r_rs2;
  assign RdE       = r_rd;
  assign LoadUseD  = w_load_use;
  assign BubbleCnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipeline_de_hz.sv
// Directed testbench for pipeline_de_hz: reset, advance, stall, load-use,
// flush priority and counter saturation (second instance with CNTW=4).
module tb_pipeline_de_hz;

  logic        clk = 1'b0;
  logic        reset, EnE, FlushE, ValidD, IsLoadD;
  logic [2:0]  CtrlD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;

  logic        ValidE, IsLoadE, LoadUseD;
  logic [2:0]  CtrlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] BubbleCnt;

  logic        s_ValidE, s_IsLoadE, s_LoadUseD;
  logic [2:0]  s_CtrlE;
  logic [31:0] s_RD1E, s_RD2E, s_PCE, s_PCPlus4E, s_ImmExtE;
  logic [4:0]  s_Rs1E, s_Rs2E, s_RdE;
  logic [3:0]  s_BubbleCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_de_hz dut (
    .clk(clk), .reset(reset), .EnE(EnE), .FlushE(FlushE), .ValidD(ValidD),
    .CtrlD(CtrlD), .IsLoadD(IsLoadD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .CtrlE(CtrlE), .IsLoadE(IsLoadE), .RD1E(RD1E), .RD2E(RD2E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .LoadUseD(LoadUseD), .BubbleCnt(BubbleCnt)
  );

  pipeline_de_hz #(.CNTW(4)) dut_sat (
    .clk(clk), .reset(reset), .EnE(EnE), .FlushE(FlushE), .ValidD(ValidD),
    .CtrlD(CtrlD), .IsLoadD(IsLoadD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(s_ValidE), .CtrlE(s_CtrlE), .IsLoadE(s_IsLoadE), .RD1E(s_RD1E),
    .RD2E(s_RD2E), .PCE(s_PCE), .PCPlus4E(s_PCPlus4E), .ImmExtE(s_ImmExtE),
    .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE), .LoadUseD(s_LoadUseD),
    .BubbleCnt(s_BubbleCnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic valid, input logic is_load, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc);
    ValidD   = valid;
    IsLoadD  = is_load;
    Rs1D     = rs1;
    Rs2D     = rs2;
    RdD      = rd;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; EnE = 1'b1; FlushE = 1'b0;
    ValidD = 1'b1; IsLoadD = 1'b1; CtrlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom;
    ImmExtD = $urandom; Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd3;
    step(); step();
    checks++;
    if ({ValidE, CtrlE, IsLoadE, Rs1E, Rs2E, RdE} !== 20'h0) begin
      errors++; $display("FAIL reset_ctrl: got %h expected 0", {ValidE, CtrlE, IsLoadE, Rs1E, Rs2E, RdE});
    end
    checks++;
    if ({RD1E, RD2E, PCE, PCPlus4E, ImmExtE} !== 160'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {RD1E, RD2E, PCE, PCPlus4E, ImmExtE});
    end
    checks++;
    if (BubbleCnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", BubbleCnt);
    end
    checks++;
    if (LoadUseD !== 1'b0) begin
      errors++; $display("FAIL reset_loaduse: got %b expected 0", LoadUseD);
    end
    reset = 1'b0;
  endtask

  task automatic test_advance();
    CtrlD = 3'd5; RD1D = 32'hDEADBEEF; RD2D = 32'h12345678; ImmExtD = 32'hFFFF_FFF0;
    drive_d(1'b1, 1'b0, 5'd1, 5'd2, 5'd7, 32'h100);
    step();
    checks++;
    if (PCE !== 32'h100 || RD1E !== 32'hDEADBEEF || RdE !== 5'd7 || ValidE !== 1'b1) begin
      errors++; $display("FAIL advance: got pc=%h rd1=%h rd=%0d v=%b expected pc=100 rd1=deadbeef rd=7 v=1",
                         PCE, RD1E, RdE, ValidE);
    end
    checks++;
    if (PCPlus4E !== 32'h104 || RD2E !== 32'h12345678 || ImmExtE !== 32'hFFFF_FFF0 || CtrlE !== 3'd5) begin
      errors++; $display("FAIL advance_fields: got pc4=%h rd2=%h imm=%h ctrl=%0d", PCPlus4E, RD2E, ImmExtE, CtrlE);
    end
  endtask

  task automatic test_stall();
    drive_d(1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 32'h100);
    step();
    EnE = 1'b0;
    drive_d(1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 32'h104);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (PCE !== 32'h100) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h expected 100", i, PCE);
      end
    end
    EnE = 1'b1;
    step();
    checks++;
    if (PCE !== 32'h104) begin
      errors++; $display("FAIL stall_release: got %h expected 104", PCE);
    end
  endtask

  task automatic test_load_use();
    drive_d(1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 32'h200);
    step();
    drive_d(1'b1, 1'b0, 5'd3, 5'd5, 5'd9, 32'h204);
    checks++;
    if (LoadUseD !== 1'b1) begin
      errors++; $display("FAIL loaduse_flag: got %b expected 1", LoadUseD);
    end
    step();
    checks++;
    if (ValidE !== 1'b0 || RdE !== 5'd0 || PCE !== 32'h0 || BubbleCnt !== 16'd1 || LoadUseD !== 1'b0) begin
      errors++; $display("FAIL loaduse_bubble: got v=%b rd=%0d pc=%h cnt=%0d lu=%b expected 0 0 0 1 0",
                         ValidE, RdE, PCE, BubbleCnt, LoadUseD);
    end
    step();
    checks++;
    if (ValidE !== 1'b1 || RdE !== 5'd9 || PCE !== 32'h204) begin
      errors++; $display("FAIL loaduse_replay: got v=%b rd=%0d pc=%h expected 1 9 204", ValidE, RdE, PCE);
    end
    // load targeting x0
    drive_d(1'b1, 1'b1, 5'd1, 5'd2, 5'd0, 32'h300);
    step();
    drive_d(1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 32'h304);
    checks++;
    if (LoadUseD !== 1'b0) begin
      errors++; $display("FAIL loaduse_x0: got %b expected 0", LoadUseD);
    end
    step();
    checks++;
    if (ValidE !== 1'b1 || PCE !== 32'h304 || BubbleCnt !== 16'd1) begin
      errors++; $display("FAIL loaduse_x0_nobubble: got v=%b pc=%h cnt=%0d expected 1 304 1", ValidE, PCE, BubbleCnt);
    end
    // invalid consumer
    drive_d(1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 32'h400);
    step();
    drive_d(1'b0, 1'b0, 5'd5, 5'd5, 5'd6, 32'h404);
    checks++;
    if (LoadUseD !== 1'b0) begin
      errors++; $display("FAIL loaduse_invalid_d: got %b expected 0", LoadUseD);
    end
    step();
    checks++;
    if (ValidE !== 1'b0 || PCE !== 32'h404 || RdE !== 5'd6 || BubbleCnt !== 16'd1) begin
      errors++; $display("FAIL invalid_load: got v=%b pc=%h rd=%0d cnt=%0d expected 0 404 6 1", ValidE, PCE, RdE, BubbleCnt);
    end
  endtask

  task automatic test_stall_hazard();
    drive_d(1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 32'h500);
    step();
    EnE = 1'b0;
    drive_d(1'b1, 1'b0, 5'd5, 5'd0, 5'd6, 32'h504);
    step();
    checks++;
    if (ValidE !== 1'b1 || RdE !== 5'd5 || PCE !== 32'h500 || BubbleCnt !== 16'd1 || LoadUseD !== 1'b1) begin
      errors++; $display("FAIL stall_hazard: got v=%b rd=%0d pc=%h cnt=%0d lu=%b expected 1 5 500 1 1",
                         ValidE, RdE, PCE, BubbleCnt, LoadUseD);
    end
  endtask

  task automatic test_flush();
    EnE = 1'b0; FlushE = 1'b1;
    step();
    checks++;
    if (ValidE !== 1'b0 || RdE !== 5'd0 || IsLoadE !== 1'b0 || BubbleCnt !== 16'd2) begin
      errors++; $display("FAIL flush_stalled: got v=%b rd=%0d ld=%b cnt=%0d expected 0 0 0 2", ValidE, RdE, IsLoadE, BubbleCnt);
    end
    EnE = 1'b1; FlushE = 1'b0;
    drive_d(1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 32'h600);
    step();
    drive_d(1'b1, 1'b0, 5'd5, 5'd0, 5'd6, 32'h604);
    FlushE = 1'b1;
    #1;
    checks++;
    if (LoadUseD !== 1'b1) begin
      errors++; $display("FAIL flush_hazard_flag: got %b expected 1", LoadUseD);
    end
    step();
    checks++;
    if (BubbleCnt !== 16'd3 || ValidE !== 1'b0) begin
      errors++; $display("FAIL flush_plus_hazard: got cnt=%0d v=%b expected 3 0", BubbleCnt, ValidE);
    end
    reset = 1'b1;
    step();
    checks++;
    if (BubbleCnt !== 16'd0 || ValidE !== 1'b0) begin
      errors++; $display("FAIL reset_over_flush: got cnt=%0d v=%b expected 0 0", BubbleCnt, ValidE);
    end
    reset = 1'b0; FlushE = 1'b0;
  endtask

  task automatic test_saturation();
    FlushE = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (s_BubbleCnt !== 4'((i > 15) ? 15 : i)) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, s_BubbleCnt, (i > 15) ? 15 : i);
      end
    end
    checks++;
    if (BubbleCnt !== 16'd20) begin
      errors++; $display("FAIL wide_cnt: got %0d expected 20", BubbleCnt);
    end
    FlushE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_advance();
    test_stall();
    test_load_use();
    test_stall_hazard();
    test_flush();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_de_hz.md
Name: pipeline_de_hz

Overview:
- Parametrised decode/execute pipeline register for the RV pipeline datapath.
- Adds a valid bit, stall (enable), flush, and on-block load-use hazard detection with automatic bubble insertion.
- Adds a saturating bubble counter for performance monitoring.
- Sits between the decode stage outputs and the execute stage inputs; the hazard unit consumes LoadUseD to stall F/D.

Parameters:
- XLEN, 32, width of data, PC and immediate fields
- CTRLW, 3, width of the control/instruction-field bundle
- REGW, 5, register index width
- CNTW, 16, bubble counter width

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- EnE  input  1  1 = stage advances, 0 = hold (stall)
- FlushE  input  1  insert bubble into E
- ValidD  input  1  D-stage instruction valid
- CtrlD  input  CTRLW  control bundle
- IsLoadD  input  1  D instruction is a load
- RD1D, RD2D  input  XLEN  register operands
- PCD, PCPlus4D  input  XLEN  PC and PC+4
- ImmExtD  input  XLEN  extended immediate
- Rs1D, Rs2D, RdD  input  REGW  source/destination indices
- ValidE, CtrlE, IsLoadE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE  output  matching widths  registered E-stage copies
- LoadUseD  output  1  combinational load-use hazard flag
- BubbleCnt  output  CNTW  bubbles inserted since reset

Behaviour:
- All E outputs are registered, with 1-cycle latency D->E when loading.
- Reset (synchronous, active-high) forces every registered output and BubbleCnt to 0. Reset has top priority and overrides flush, hazard and stall in the same cycle.
- LoadUseD = ValidE & IsLoadE & (RdE != 0) & ValidD & ((Rs1D == RdE) | (Rs2D == RdE)).
  - Purely combinational from E state and D inputs; no internal state.
  - RdE = 0 never produces a hazard.
- Per-edge priority (reset aside):
  1. FlushE=1: bubble, regardless of EnE.
  2. EnE=1 & LoadUseD=1: bubble.
  3. EnE=0: hold all E registers unchanged.
  4. EnE=1: load all D inputs.
- Bubble = all E registers, including data fields, written to 0. ValidE=0, CtrlE=0, IsLoadE=0, RdE=0.
- A bubble clears the hazard condition on the next cycle, because ValidE becomes 0.
- FlushE and LoadUseD asserted together produce one bubble and one count increment.
- Stall with hazard pending (EnE=0, LoadUseD=1): hold; no bubble, no count; LoadUseD stays asserted.
- BubbleCnt:
  - Increments by 1 on each edge where a bubble is written.
  - Saturates at 2^CNTW-1 and never wraps.
  - Cleared only by reset.
- Invalid D instruction (ValidD=0) loads normally with ValidE=0. It never triggers a hazard as consumer.

Test Plan:
- Reset: drive random D inputs with reset=1 for 2 cycles -> all E outputs 0, BubbleCnt=0, LoadUseD=0.
- Normal advance: EnE=1, ValidD=1, PCD=0x100, RD1D=0xDEADBEEF, RdD=7 -> next cycle PCE=0x100, RD1E=0xDEADBEEF, RdE=7, ValidE=1.
- Stall: load PCD=0x100, then EnE=0 with PCD=0x104 for 3 cycles -> PCE stays 0x100; after EnE=1, PCE=0x104 one cycle later.
- Load-use: E holds a valid load with RdE=5.
  - D has Rs2D=5, EnE=1 -> LoadUseD=1 same cycle; next cycle ValidE=0, RdE=0, BubbleCnt=1, LoadUseD=0.
  - Repeat with RdE=0 -> LoadUseD=0, no bubble.
- Flush priority:
  - FlushE=1 with EnE=0 -> bubble written, BubbleCnt+1.
  - FlushE=1 together with LoadUseD=1 -> single increment.
  - reset=1 together with FlushE=1 -> BubbleCnt=0.
- Saturation: CNTW=4, 20 consecutive FlushE cycles -> BubbleCnt reaches 15 and stays 15.
